// File: rtl/porta_serial_tx.sv
// Memory-mapped 8N1 serial transmitter with an 8-entry transmit FIFO.
// The CPU writes bytes to END_DADOS; END_CTRL clears overflow (bit0) or flushes the FIFO (bit1).
module porta_serial_tx #(
  parameter int unsigned DIV_BAUD  = 16,
  parameter logic [7:0]  END_DADOS = 8'hE0,
  parameter logic [7:0]  END_CTRL  = 8'hE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] endereco,
  input  logic [7:0] dado_in,
  input  logic       write,
  output logic       tx,
  output logic       fifo_cheio,
  output logic       fifo_vazio,
  output logic       ocupado,
  output logic [3:0] nivel,
  output logic       overflow
);

  localparam logic [7:0] BAUD_MAX = 8'(DIV_BAUD - 1);

  typedef enum logic [1:0] {OCIOSO, START, DADOS, STOP} estado_t;

  estado_t    estado, estado_n;
  logic [7:0] baud_cnt, baud_cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic       tx_n;

  logic [7:0] mem [8];
  logic [2:0] wr_ptr, rd_ptr;
  logic [3:0] count;

  logic push_req, ctrl_wr, flush, pop, push_ok;

  assign push_req = write && (endereco == END_DADOS);
  assign ctrl_wr  = write && (endereco == END_CTRL);
  assign flush    = ctrl_wr && dado_in[1];

  assign fifo_vazio = (count == 4'd0);
  assign fifo_cheio = (count == 4'd8);
  assign nivel      = count;
  assign ocupado    = (estado != OCIOSO);

  // A flush in the same cycle suppresses the pop, so the FSM stays idle.
  assign pop     = (estado == OCIOSO) && !fifo_vazio && !flush;
  assign push_ok = push_req && (!fifo_cheio || pop) && !flush;

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= dado_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 3'd1;
        if (pop)     rd_ptr <= rd_ptr + 3'd1;
        count <= count + 4'(push_ok) - 4'(pop);
      end
      if (ctrl_wr && dado_in[0])
        overflow <= 1'b0;
      else if (push_req && !push_ok)
        overflow <= 1'b1;
    end
  end

  always_comb begin
    estado_n   = estado;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    tx_n       = 1'b1;
    case (estado)
      OCIOSO: begin
        if (pop) begin
          shift_n    = mem[rd_ptr];
          bit_cnt_n  = '0;
          baud_cnt_n = '0;
          estado_n   = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (baud_cnt == BAUD_MAX) begin
          baud_cnt_n = '0;
          estado_n   = DADOS;
        end else begin
          baud_cnt_n = baud_cnt + 8'd1;
        end
      end
      DADOS: begin
        tx_n = shift[0];
        if (baud_cnt == BAUD_MAX) begin
          baud_cnt_n = '0;
          shift_n    = {1'b0, shift[7:1]};
          bit_cnt_n  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) estado_n = STOP;
        end else begin
          baud_cnt_n = baud_cnt + 8'd1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (baud_cnt == BAUD_MAX) begin
          baud_cnt_n = '0;
          estado_n   = OCIOSO;
        end else begin
          baud_cnt_n = baud_cnt + 8'd1;
        end
      end
      default: estado_n = OCIOSO;
    endcase
  end

  // tx is registered from the current state, so the line lags the FSM by one clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= OCIOSO;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      estado   <= estado_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      tx       <= tx_n;
    end
  end

endmodule

// File: tb/tb_porta_serial_tx.sv
// Directed bench for porta_serial_tx with DIV_BAUD=4; a line monitor decodes frames from tx.
module tb_porta_serial_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] endereco = '0;
  logic [7:0] dado_in = '0;
  logic       write = 1'b0;
  logic       tx, fifo_cheio, fifo_vazio, ocupado, overflow;
  logic [3:0] nivel;

  porta_serial_tx #(.DIV_BAUD(4), .END_DADOS(8'hE0), .END_CTRL(8'hE1)) dut (
    .clock      (clock),
    .reset      (reset),
    .endereco   (endereco),
    .dado_in    (dado_in),
    .write      (write),
    .tx         (tx),
    .fifo_cheio (fifo_cheio),
    .fifo_vazio (fifo_vazio),
    .ocupado    (ocupado),
    .nivel      (nivel),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [9:0] rxq [$];
  int         rx_start [$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Samples each bit mid-period: 2 clocks after the first low sample, then every 4.
  initial begin : rx_monitor
    logic [9:0] f;
    int c;
    forever begin
      @(negedge clock);
      if (tx === 1'b0) begin
        c = cyc;
        repeat (2) @(negedge clock);
        f[0] = tx;
        for (int k = 1; k < 10; k++) begin
          repeat (4) @(negedge clock);
          f[k] = tx;
        end
        rxq.push_back(f);
        rx_start.push_back(c);
      end
    end
  end

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    endereco = a;
    dado_in  = d;
    write    = 1'b1;
    @(negedge clock);
    write    = 1'b0;
    endereco = '0;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] b, output int st);
    logic [9:0] f;
    st = -1;
    for (int i = 0; i < 60 && rxq.size() == 0; i++) @(negedge clock);
    check({tag, "_arrived"}, 32'(rxq.size() > 0), 32'd1);
    if (rxq.size() > 0) begin
      f  = rxq.pop_front();
      st = rx_start.pop_front();
      check(tag, 32'(f), 32'({1'b1, b, 1'b0}));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int occ, st1, st2;

    repeat (3) @(negedge clock);
    check("rst_tx", tx, 1);
    check("rst_nivel", nivel, 0);
    check("rst_vazio", fifo_vazio, 1);
    check("rst_cheio", fifo_cheio, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b1;
    @(negedge clock);

    // single frame, latency and busy length
    bus_wr(8'hE0, 8'hA5);
    check("a5_nivel", nivel, 1);
    occ = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (i == 0) check("a5_tx_pre", tx, 1);
      if (i == 1) check("a5_tx_fall", tx, 0);
      if (ocupado) occ++;
      else if (occ > 0) break;
    end
    check("a5_ocupado_len", occ, 40);
    expect_frame("frame_a5", 8'hA5, st1);

    // fill to full, overflow, clear
    for (int i = 1; i <= 9; i++) bus_wr(8'hE0, 8'(i));
    check("fill_nivel", nivel, 8);
    check("fill_cheio", fifo_cheio, 1);
    check("fill_overflow", overflow, 0);
    bus_wr(8'hE0, 8'hFF);
    check("ovf_set", overflow, 1);
    check("ovf_nivel", nivel, 8);
    bus_wr(8'hE1, 8'h01);
    check("ovf_clr", overflow, 0);
    for (int i = 1; i <= 9; i++) expect_frame("frame_seq", 8'(i), st1);
    repeat (60) @(negedge clock);
    check("no_ff_frame", rxq.size(), 0);
    check("seq_vazio", fifo_vazio, 1);

    // flush beats pop in the same cycle
    bus_wr(8'hE0, 8'h12);
    bus_wr(8'hE1, 8'h02);
    check("flushpop_ocupado", ocupado, 0);
    check("flushpop_nivel", nivel, 0);
    repeat (50) @(negedge clock);
    check("flushpop_noframe", rxq.size(), 0);

    // flush mid-frame
    bus_wr(8'hE0, 8'h3C);
    bus_wr(8'hE0, 8'h55);
    bus_wr(8'hE0, 8'h66);
    bus_wr(8'hE0, 8'h77);
    check("flush_pre_nivel", nivel, 3);
    repeat (12) @(negedge clock);
    bus_wr(8'hE1, 8'h02);
    check("flush_nivel", nivel, 0);
    check("flush_ocupado", ocupado, 1);
    expect_frame("frame_3c", 8'h3C, st1);
    repeat (60) @(negedge clock);
    check("flush_noframe", rxq.size(), 0);
    check("flush_tx_idle", tx, 1);
    check("flush_idle", ocupado, 0);

    // reset mid-DADOS
    bus_wr(8'hE0, 8'h5A);
    bus_wr(8'hE0, 8'h6B);
    repeat (15) @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_nivel", nivel, 0);
    check("mid_rst_ocupado", ocupado, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (60) @(negedge clock);
    rxq.delete();
    rx_start.delete();
    bus_wr(8'hE0, 8'hC3);
    expect_frame("frame_c3", 8'hC3, st1);
    repeat (60) @(negedge clock);
    check("rst_discard", rxq.size(), 0);

    // other address ignored, back-to-back gap
    bus_wr(8'hE2, 8'h77);
    check("e2_nivel", nivel, 0);
    check("e2_ocupado", ocupado, 0);
    bus_wr(8'hE0, 8'h11);
    bus_wr(8'hE0, 8'h22);
    bus_wr(8'hE2, 8'h99);
    check("b2b_nivel", nivel, 1);
    expect_frame("frame_11", 8'h11, st1);
    expect_frame("frame_22", 8'h22, st2);
    check("b2b_gap", st2 - st1, 41);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/porta_serial_tx.md
PORTA_SERIAL_TX -- requirements
Module: porta_serial_tx

Interface
REQ-001 Parameter DIV_BAUD, default 16: clocks per serial bit, legal range 2..255.
REQ-002 Parameter END_DADOS, default 8'hE0: address of the transmit-data register.
REQ-003 Parameter END_CTRL, default 8'hE1: address of the control register.
REQ-004 Port clock, input, 1: single system clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port endereco, input, 8: processor bus address.
REQ-007 Port dado_in, input, 8: processor bus write data.
REQ-008 Port write, input, 1: bus write strobe, sampled on the rising clock edge.
REQ-009 Port tx, output, 1: serial line, 8N1 format, idle high.
REQ-010 Port fifo_cheio, output, 1: FIFO holds 8 entries.
REQ-011 Port fifo_vazio, output, 1: FIFO holds 0 entries.
REQ-012 Port ocupado, output, 1: a frame is being shifted out (FSM state is not OCIOSO).
REQ-013 Port nivel, output, 4: FIFO occupancy, 0..8.
REQ-014 Port overflow, output, 1: sticky flag, set when a write is dropped.

Function
REQ-015 Push: a push occurs when write=1 and endereco=END_DADOS; dado_in enters the FIFO tail.
REQ-016 FIFO: 8 entries x 8 bits, circular, with 3-bit read/write pointers that wrap 7->0.
REQ-017 Push while full with no pop in the same cycle: data dropped, overflow<=1, FIFO unchanged.
REQ-018 Push while full with a pop in the same cycle: push accepted; nivel stays 8.
REQ-019 Push and pop in the same cycle with 0<nivel<8: both performed; nivel unchanged.
REQ-020 Control write: active when write=1 and endereco=END_CTRL.
REQ-021 Control bit0=1 clears overflow.
REQ-022 Control bit1=1 flushes the FIFO: pointers<=0, nivel<=0. A frame already in progress completes.
REQ-023 Flush and pop in the same cycle: the flush wins.
REQ-024 Writes to any other address are ignored.
REQ-025 Transmit FSM states: OCIOSO, START, DADOS, STOP.
REQ-026 OCIOSO with fifo_vazio=0: pop the head into the shift register, bit counter<=0, baud counter<=0, go to START on the same edge.
REQ-027 OCIOSO with fifo_vazio=1: stay in OCIOSO, tx=1.
REQ-028 START: tx=0 for DIV_BAUD clocks, then go to DADOS.
REQ-029 DADOS: tx=shift[0], LSB first; each bit lasts DIV_BAUD clocks, then shift right; after bit 7, go to STOP.
REQ-030 STOP: tx=1 for DIV_BAUD clocks, then go to OCIOSO.
REQ-031 Back-to-back frames: if the FIFO is non-empty on return to OCIOSO, the next pop follows one clock later, so the frame-to-frame gap is exactly 1 idle clock.
REQ-032 Frame length: 10*DIV_BAUD clocks from START entry to STOP exit.
REQ-033 Push-to-tx latency from an empty, idle block: tx falls on the second rising edge after the push edge.
REQ-034 tx, ocupado, fifo_cheio, fifo_vazio, nivel and overflow are registered or decoded from registered state only; there is no combinational path from bus inputs.

Reset
REQ-035 reset=0 asynchronously forces: FSM=OCIOSO, tx=1, pointers=0, nivel=0, fifo_vazio=1, fifo_cheio=0, ocupado=0, overflow=0, baud and bit counters=0.
REQ-036 Reset asserted mid-frame aborts the frame immediately (tx=1); FIFO contents are discarded.
REQ-037 After reset release, the first rising edge behaves as OCIOSO with an empty FIFO.

Verification
REQ-038 DIV_BAUD=4, push 8'hA5 -> tx samples every 4 clocks read 0,1,0,1,0,0,1,0,1,1; ocupado high for 40 clocks.
REQ-039 Push 9 bytes 8'h01..8'h09 on consecutive cycles while idle -> the first is popped at once, all 9 stored, fifo_cheio=1, overflow=0; transmitted order is 01..09.
REQ-040 With nivel=8 and the FSM busy, push 8'hFF -> overflow=1, nivel=8, 8'hFF is never transmitted; then a control write of 8'h01 -> overflow=0.
REQ-041 Mid-frame of 8'h3C with nivel=3, control write 8'h02 -> 8'h3C completes with correct bits, nivel=0, then tx stays 1.
REQ-042 Mid-DADOS, pulse reset low for 1 clock -> tx=1 at once, nivel=0, ocupado=0; the next push starts a clean frame.
REQ-043 Push 8'h11 then 8'h22 back-to-back -> the second START begins exactly 1 clock after the first STOP ends; a write to 8'hE2 has no effect.
